kim_if_stage_p: RTL and testbench

//  Instruction-fetch stage of the 5-stage pipelined MIPS core; sits directly downstream of the PC register.

---
 rtl/kim_if_stage_p.sv | 205 ++++++++++++++++++++
 tb/tb_kim_if_stage_p.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kim_if_stage_p.sv
// Instruction-fetch stage: one imem request per PC, one-entry hold buffer, IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_wait_cnt outputs.
module kim_if_stage_p #(
   parameter int                     PC_ADDR_WIDTH = 32,
   parameter int                     INSTR_WIDTH   = 32,
   parameter logic [INSTR_WIDTH-1:0] RESET_INSTR   = {INSTR_WIDTH{1'b0}}
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [PC_ADDR_WIDTH-1:0] pc,
   output logic                     pc_stall,
   output logic [PC_ADDR_WIDTH-1:0] pc_plus4,
   output logic                     imem_req,
   output logic [PC_ADDR_WIDTH-1:0] imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [INSTR_WIDTH-1:0]   imem_rdata,
   input  logic                     id_stall,
   input  logic                     flush,
   output logic                     id_valid,
   output logic [PC_ADDR_WIDTH-1:0] id_pc,
   output logic [PC_ADDR_WIDTH-1:0] id_pc_plus4,
   output logic [INSTR_WIDTH-1:0]   id_instr
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]              perf_fetch_cnt,
   output logic [31:0]              perf_wait_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   localparam logic [PC_ADDR_WIDTH-1:0] PC_INC = PC_ADDR_WIDTH'(3'd4);

   state_t                     state_r;
   state_t                     state_s;
   logic [PC_ADDR_WIDTH-1:0]   req_pc_r;
   logic [PC_ADDR_WIDTH-1:0]   hold_pc_r;
   logic [INSTR_WIDTH-1:0]     hold_instr_r;
   logic                       id_valid_r;
   logic [PC_ADDR_WIDTH-1:0]   id_pc_r;
   logic [PC_ADDR_WIDTH-1:0]   id_pc_plus4_r;
   logic [INSTR_WIDTH-1:0]     id_instr_r;

   logic                       id_can_load_s;
   logic                       latch_req_s;
   logic                       store_hold_s;
   logic                       clear_hold_s;
   logic                       load_s;
   logic [PC_ADDR_WIDTH-1:0]   load_pc_s;
   logic [INSTR_WIDTH-1:0]     load_instr_s;

   // Combinational handshake towards the PC register and imem; flush always frees the PC.
   always_comb begin
      imem_req      = (state_r == ST_REQ) && !flush;
      imem_addr     = {pc[PC_ADDR_WIDTH-1:2], 2'b00};
      pc_stall      = !flush && !((state_r == ST_REQ) && imem_gnt);
      pc_plus4      = pc + PC_INC;
      id_can_load_s = !id_stall || !id_valid_r;
   end

   // Next-state and datapath steering for the fetch FSM.
   always_comb begin
      state_s      = state_r;
      latch_req_s  = 1'b0;
      store_hold_s = 1'b0;
      clear_hold_s = 1'b0;
      load_s       = 1'b0;
      load_pc_s    = {PC_ADDR_WIDTH{1'b0}};
      load_instr_s = {INSTR_WIDTH{1'b0}};
      case (state_r)
         ST_REQ: begin
            if (imem_gnt && !flush) begin
               latch_req_s = 1'b1;
               state_s     = ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid && flush) begin
               state_s = ST_REQ;
            end else if (flush) begin
               state_s = ST_DROP;
            end else if (imem_rvalid) begin
               if (id_can_load_s) begin
                  load_s       = 1'b1;
                  load_pc_s    = req_pc_r;
                  load_instr_s = imem_rdata;
                  state_s      = ST_REQ;
               end else begin
                  store_hold_s = 1'b1;
                  state_s      = ST_HOLD;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (flush) begin
               clear_hold_s = 1'b1;
               state_s      = ST_REQ;
            end else if (!id_stall) begin
               load_s       = 1'b1;
               load_pc_s    = hold_pc_r;
               load_instr_s = hold_instr_r;
               clear_hold_s = 1'b1;
               state_s      = ST_REQ;
            end else begin
               state_s = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_DROP;
            end
         end
         default: begin
            state_s = ST_REQ;
         end
      endcase
   end

   // FSM state, request PC and hold buffer registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= ST_REQ;
         req_pc_r     <= {PC_ADDR_WIDTH{1'b0}};
         hold_pc_r    <= {PC_ADDR_WIDTH{1'b0}};
         hold_instr_r <= {INSTR_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         if (latch_req_s) begin
            req_pc_r <= pc;
         end
         if (store_hold_s) begin
            hold_pc_r    <= req_pc_r;
            hold_instr_r <= imem_rdata;
         end else if (clear_hold_s) begin
            hold_pc_r    <= {PC_ADDR_WIDTH{1'b0}};
            hold_instr_r <= {INSTR_WIDTH{1'b0}};
         end
      end
   end

   // IF/ID register: flush beats stall, a stalled valid entry holds, otherwise load or go empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         id_valid_r    <= 1'b0;
         id_pc_r       <= {PC_ADDR_WIDTH{1'b0}};
         id_pc_plus4_r <= {PC_ADDR_WIDTH{1'b0}};
         id_instr_r    <= RESET_INSTR;
      end else if (flush) begin
         id_valid_r <= 1'b0;
         id_instr_r <= RESET_INSTR;
      end else if (id_stall && id_valid_r) begin
         id_valid_r <= id_valid_r;
      end else if (load_s) begin
         id_valid_r    <= 1'b1;
         id_pc_r       <= load_pc_s;
         id_pc_plus4_r <= load_pc_s + PC_INC;
         id_instr_r    <= load_instr_s;
      end else begin
         id_valid_r <= 1'b0;
      end
   end

   assign id_valid    = id_valid_r;
   assign id_pc       = id_pc_r;
   assign id_pc_plus4 = id_pc_plus4_r;
   assign id_instr    = id_instr_r;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt_r;
   logic [31:0] perf_wait_cnt_r;

   // load_s already excludes flushed and stalled cases, so it marks a real IF/ID entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_fetch_cnt_r <= 32'd0;
         perf_wait_cnt_r  <= 32'd0;
      end else begin
         if (load_s) begin
            perf_fetch_cnt_r <= perf_fetch_cnt_r + 32'd1;
         end
         if ((state_r == ST_WAIT) || (state_r == ST_DROP)) begin
            perf_wait_cnt_r <= perf_wait_cnt_r + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = perf_fetch_cnt_r;
   assign perf_wait_cnt  = perf_wait_cnt_r;
`else
   // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_kim_if_stage_p.sv
// Self-checking bench for kim_if_stage_p: directed scenarios followed by randomized traffic
// checked against a transaction-level model of fetches, the hold slot and the IF/ID register.
module tb_kim_if_stage_p;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc = 32'd0;
   logic        pc_stall;
   logic [31:0] pc_plus4;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        id_stall = 1'b0;
   logic        flush = 1'b0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;

   always #5 clk = ~clk;

   kim_if_stage_p dut (
      .clk         (clk),
      .rstn        (rstn),
      .pc          (pc),
      .pc_stall    (pc_stall),
      .pc_plus4    (pc_plus4),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_stall    (id_stall),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4),
      .id_instr    (id_instr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // environment: PC register, memory, knobs
   logic [31:0] bench_pc = 32'd0;
   logic [31:0] redirect = 32'd0;
   int          lat = 0;
   logic        mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'd0;
   logic        last_pc_stall = 1'b0;

   // reference model: outstanding fetch, squash flag, hold slot, IF/ID contents
   logic        m_out = 1'b0, m_sq = 1'b0, m_pend = 1'b0;
   logic [31:0] m_pc = 32'd0, m_ppc = 32'd0, m_pinstr = 32'd0;
   logic        e_valid = 1'b0;
   logic [31:0] e_pc = 32'd0, e_pp4 = 32'd0, e_instr = 32'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h2001_0001;
         32'h0000_0004: mem_word = 32'h2002_0002;
         32'h0000_0008: mem_word = 32'hAC03_0000;
         default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   task automatic cycle(input logic fl, input logic st, input logic gn, input logic unsol);
      logic        e_req, e_stall, deliver, can, have_new;
      logic [31:0] n_pc, n_instr;
      @(negedge clk);
      pc          = bench_pc;
      flush       = fl;
      id_stall    = st;
      imem_rvalid = (mem_busy && mem_cnt == 0) || (unsol && !mem_busy);
      imem_rdata  = mem_busy ? mem_word(mem_addr) : $urandom;
      imem_gnt    = gn && !mem_busy;
      #1;
      last_pc_stall = pc_stall;
      e_req   = !m_out && !m_pend && !fl;
      e_stall = !fl && !(!m_out && !m_pend && imem_gnt);
      chk("imem_req",    32'(imem_req), 32'(e_req));
      chk("pc_stall",    32'(pc_stall), 32'(e_stall));
      chk("imem_addr",   imem_addr, bench_pc & 32'hFFFF_FFFC);
      chk("pc_plus4",    pc_plus4, bench_pc + 32'd4);
      chk("id_valid",    32'(id_valid), 32'(e_valid));
      chk("id_pc",       id_pc, e_pc);
      chk("id_pc_plus4", id_pc_plus4, e_pp4);
      chk("id_instr",    id_instr, e_instr);

      deliver  = m_out && !m_sq && imem_rvalid && !fl;
      can      = !st || !e_valid;
      have_new = 1'b0;
      n_pc     = 32'd0;
      n_instr  = 32'd0;
      if (m_pend && !st && !fl) begin
         have_new = 1'b1; n_pc = m_ppc; n_instr = m_pinstr; m_pend = 1'b0;
      end else if (deliver && can) begin
         have_new = 1'b1; n_pc = m_pc; n_instr = mem_word(m_pc & 32'hFFFF_FFFC);
      end
      if (deliver && !can) begin
         m_pend = 1'b1; m_ppc = m_pc; m_pinstr = mem_word(m_pc & 32'hFFFF_FFFC);
      end
      if (fl) m_pend = 1'b0;
      if (m_out && imem_rvalid) m_out = 1'b0;
      else if (m_out && fl) m_sq = 1'b1;
      if (e_req && imem_gnt) begin
         m_out = 1'b1; m_sq = 1'b0; m_pc = bench_pc;
      end
      if (fl) begin
         e_valid = 1'b0; e_instr = 32'd0;
      end else if (st && e_valid) begin
         e_valid = e_valid;
      end else if (have_new) begin
         e_valid = 1'b1; e_pc = n_pc; e_pp4 = n_pc + 32'd4; e_instr = n_instr;
      end else begin
         e_valid = 1'b0;
      end
      if (!e_stall) bench_pc = fl ? redirect : bench_pc + 32'd4;

      if (mem_busy && imem_rvalid) mem_busy = 1'b0;
      else if (mem_busy && mem_cnt != 0) mem_cnt--;
      if (imem_req && imem_gnt) begin
         mem_busy = 1'b1; mem_cnt = lat; mem_addr = imem_addr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; flush = 1'b0; id_stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      bench_pc = 32'd0; pc = 32'd0;
      m_out = 1'b0; m_sq = 1'b0; m_pend = 1'b0;
      e_valid = 1'b0; e_pc = 32'd0; e_pp4 = 32'd0; e_instr = 32'd0;
      #1;
      chk("rst_id_valid",    32'(id_valid), 32'd0);
      chk("rst_id_pc",       id_pc, 32'd0);
      chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
      chk("rst_id_instr",    id_instr, 32'd0);
      chk("rst_imem_req",    32'(imem_req), 32'd1);
      chk("rst_imem_addr",   imem_addr, 32'd0);
      if (mem_busy && mem_cnt != 0) mem_cnt--;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      logic [31:0] p;
      do_reset();

      // back-to-back fetches, one-cycle memory
      lat = 0;
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_valid0", 32'(id_valid), 32'd1);
      chk("t1_instr0", id_instr, 32'h2001_0001);
      chk("t1_pc0",    id_pc, 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_gap", 32'(id_valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_instr1", id_instr, 32'h2002_0002);
      chk("t1_pc1",    id_pc, 32'd4);
      chk("t1_pp4_1",  id_pc_plus4, 32'd8);

      // decode stall while a response arrives -> hold buffer
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t3_held_pc",    id_pc, 32'd4);
      chk("t3_held_instr", id_instr, 32'h2002_0002);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3_pc",    id_pc, 32'd8);
      chk("t3_instr", id_instr, 32'hAC03_0000);
      chk("t3_valid", 32'(id_valid), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_nodup", 32'(id_valid), 32'd0);

      // flush during WAIT, late response dropped
      lat = 2; redirect = 32'h0000_0100;
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_dropped", 32'(id_valid), 32'd0);
      chk("t4_req",     32'(imem_req), 32'd1);
      chk("t4_addr",    imem_addr, 32'h0000_0100);

      // flush together with stall on a valid IF/ID entry
      lat = 0; redirect = 32'h0000_0200;
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_pre_valid", 32'(id_valid), 32'd1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5_pc_stall", 32'(last_pc_stall), 32'd0);
      chk("t5_valid",    32'(id_valid), 32'd0);
      chk("t5_instr",    id_instr, 32'd0);

      // slow memory: PC held through WAIT
      lat = 2; p = bench_pc;
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0);
         chk("t2_stall", 32'(last_pc_stall), 32'd1);
      end
      chk("t2_valid", 32'(id_valid), 32'd1);
      chk("t2_instr", id_instr, mem_word(p));
      chk("t2_pc",    id_pc, p);

      // reset in WAIT; stale response must be ignored afterwards
      lat = 3;
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      do_reset();
      #1;
      chk("t6_req",  32'(imem_req), 32'd1);
      chk("t6_addr", imem_addr, 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         lat      = int'($urandom_range(0, 3));
         redirect = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
